// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side consumer stage for the asynchronous FIFO. It runs entirely in the
// read clock domain and pops words through the FIFO's first-word-fall-through
// port. Those words are re-presented as a registered valid/ready stream
// through a 2-entry skid buffer, and the stream is framed into fixed-length
// bursts with m_last.
//
// Parameters:
//   DSIZE      data width, matches the FIFO DSIZE
//   BURST_LEN  beats per burst, 1..2^CW
//   CW         beat counter width
//
// Ports:
//   clk         read-domain clock (FIFO rclk)
//   rst         asynchronous active-low reset
//   en          pop enable; buffered words still drain while low
//   rempty      FIFO empty flag
//   rdata       FIFO head word, valid while rempty=0
//   rinc        FIFO pop strobe
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_data      output word
//   m_last      final beat of the current burst
//   beat_cnt    beat index within the current burst
//   burst_done  one-cycle pulse after the last beat is accepted
module fifo_rd_stream #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4,
  parameter int CW        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic [CW-1:0]    beat_cnt,
  output logic             burst_done
);

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  occ_t             occ, occ_nxt;
  logic [DSIZE-1:0] head, head_nxt;
  logic [DSIZE-1:0] skid, skid_nxt;
  logic [CW-1:0]    beat_nxt;
  logic             done_nxt;
  logic             pop;
  logic             hs;
  logic             at_last;

  // Pop decision depends only on registered occupancy and the FIFO flag, so
  // there is no combinational path from m_ready to rinc. Gating with rst keeps
  // rinc low for the whole reset window, not just after the first edge.
  assign pop      = rst & en & ~rempty & (occ != OCC_2);
  assign rinc     = pop;
  assign m_valid  = (occ != OCC_0);
  assign m_data   = head;
  assign at_last  = (beat_cnt == LAST_BEAT);
  assign m_last   = m_valid & at_last;
  assign hs       = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ        <= OCC_0;
      head       <= '0;
      skid       <= '0;
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      occ        <= occ_nxt;
      head       <= head_nxt;
      skid       <= skid_nxt;
      beat_cnt   <= beat_nxt;
      burst_done <= done_nxt;
    end
  end

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    skid_nxt = skid;
    case (occ)
      OCC_0: begin
        if (pop) begin
          head_nxt = rdata;
          occ_nxt  = OCC_1;
        end
      end
      OCC_1: begin
        if (pop && hs) begin
          head_nxt = rdata;
        end else if (pop) begin
          skid_nxt = rdata;
          occ_nxt  = OCC_2;
        end else if (hs) begin
          occ_nxt  = OCC_0;
        end
      end
      OCC_2: begin
        if (hs) begin
          head_nxt = skid;
          occ_nxt  = OCC_1;
        end
      end
      default: occ_nxt = OCC_0;
    endcase
  end

  always_comb begin
    beat_nxt = beat_cnt;
    done_nxt = 1'b0;
    if (hs) begin
      if (at_last) begin
        beat_nxt = '0;
        done_nxt = 1'b1;
      end else begin
        beat_nxt = beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a BURST_LEN=4 instance driven by directed
// vector tables and hand sequences, plus a BURST_LEN=1 instance.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       force_empty = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_ready1 = 1'b0;

  logic       rempty, rinc, m_valid, m_last, burst_done;
  logic [7:0] rdata, m_data;
  logic [3:0] beat_cnt;

  logic       rempty1, rinc1, m_valid1, m_last1, burst_done1;
  logic [7:0] rdata1, m_data1;
  logic [3:0] beat_cnt1;

  int checks = 0;
  int failures = 0;

  // FIFO models (first-word-fall-through)
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

  assign rempty  = (rd0 == wr0) | force_empty;
  assign rdata   = mem0[rd0 % 64];
  assign rempty1 = (rd1 == wr1) | force_empty;
  assign rdata1  = mem1[rd1 % 64];

  always @(posedge clk) begin
    if (rinc)  rd0 <= rd0 + 1;
    if (rinc1) rd1 <= rd1 + 1;
  end

  always #5 clk = ~clk;

  fifo_rd_stream #(.DSIZE(8), .BURST_LEN(4), .CW(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .beat_cnt(beat_cnt), .burst_done(burst_done)
  );

  fifo_rd_stream #(.DSIZE(8), .BURST_LEN(1), .CW(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .rempty(rempty1), .rdata(rdata1),
    .rinc(rinc1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .m_last(m_last1), .beat_cnt(beat_cnt1), .burst_done(burst_done1)
  );

  typedef struct {
    logic       en, rdy, fe;
    logic       rinc, valid;
    logic [7:0] data;
    logic       last;
    logic [3:0] beat;
    logic       done;
  } row_t;

  row_t tbl[$];

  function automatic row_t v(input logic en_i, input logic rdy, input logic fe,
                             input logic ri, input logic va, input logic [7:0] d,
                             input logic la, input logic [3:0] be, input logic dn);
    row_t r;
    r.en = en_i; r.rdy = rdy; r.fe = fe; r.rinc = ri; r.valid = va;
    r.data = d; r.last = la; r.beat = be; r.done = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Push words while holding the FIFO flag empty so the next edge cannot pop.
  task automatic push0(input logic [7:0] d);
    force_empty = 1'b1;
    mem0[wr0 % 64] = d;
    wr0++;
  endtask

  task automatic push1(input logic [7:0] d);
    force_empty = 1'b1;
    mem1[wr1 % 64] = d;
    wr1++;
  endtask

  task automatic apply(input row_t r, input string tag);
    @(negedge clk);
    en = r.en; m_ready = r.rdy; force_empty = r.fe;
    #1;
    chk({tag, "_rinc"},  32'(rinc),       32'(r.rinc));
    chk({tag, "_valid"}, 32'(m_valid),    32'(r.valid));
    if (r.valid) chk({tag, "_data"}, 32'(m_data), 32'(r.data));
    chk({tag, "_last"},  32'(m_last),     32'(r.last));
    chk({tag, "_beat"},  32'(beat_cnt),   32'(r.beat));
    chk({tag, "_done"},  32'(burst_done), 32'(r.done));
  endtask

  initial begin
    // Test 1: 4-word burst, m_ready=1 (rows 0..6)
    tbl.push_back(v(1,1,0, 1,0,8'h00,0,0,0));
    tbl.push_back(v(1,1,0, 1,1,8'h11,0,0,0));
    tbl.push_back(v(1,1,0, 1,1,8'h22,0,1,0));
    tbl.push_back(v(1,1,0, 1,1,8'h33,0,2,0));
    tbl.push_back(v(1,1,0, 0,1,8'h44,1,3,0));
    tbl.push_back(v(1,1,0, 0,0,8'h00,0,0,1));
    tbl.push_back(v(1,1,0, 0,0,8'h00,0,0,0));
    // Test 2: back-pressure for 5 cycles then release (rows 7..16)
    tbl.push_back(v(1,0,0, 1,0,8'h00,0,0,0));
    tbl.push_back(v(1,0,0, 1,1,8'hA1,0,0,0));
    tbl.push_back(v(1,0,0, 0,1,8'hA1,0,0,0));
    tbl.push_back(v(1,0,0, 0,1,8'hA1,0,0,0));
    tbl.push_back(v(1,0,0, 0,1,8'hA1,0,0,0));
    tbl.push_back(v(1,1,0, 0,1,8'hA1,0,0,0));
    tbl.push_back(v(1,1,0, 1,1,8'hA2,0,1,0));
    tbl.push_back(v(1,1,0, 1,1,8'hA3,0,2,0));
    tbl.push_back(v(1,1,0, 0,1,8'hA4,1,3,0));
    tbl.push_back(v(1,1,0, 0,0,8'h00,0,0,1));

    // Reset state, with rst held low
    #1;
    chk("rst_rinc",  32'(rinc),       32'd0);
    chk("rst_valid", 32'(m_valid),    32'd0);
    chk("rst_data",  32'(m_data),     32'd0);
    chk("rst_last",  32'(m_last),     32'd0);
    chk("rst_beat",  32'(beat_cnt),   32'd0);
    chk("rst_done",  32'(burst_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h44);
    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("t1_row%0d", i));
    push0(8'hA1); push0(8'hA2); push0(8'hA3); push0(8'hA4);
    for (int i = 7; i < 17; i++) apply(tbl[i], $sformatf("t2_row%0d", i));

    // Test 3: m_ready toggling with rempty alternating; scoreboard model
    begin
      logic [7:0] sbq[$];
      int acc = 0;
      logic exp_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        push0(8'hE0 + 8'(k));
        sbq.push_back(8'hE0 + 8'(k));
      end
      for (int i = 0; i < 60 && acc < 8; i++) begin
        @(negedge clk);
        en = 1'b1;
        force_empty = (i % 2 == 0);
        m_ready = (i % 2 == 0);
        #1;
        chk($sformatf("t3_done_c%0d", i), 32'(burst_done), 32'(exp_done));
        chk($sformatf("t3_beat_c%0d", i), 32'(beat_cnt), 32'(acc % 4));
        if (m_valid)
          chk($sformatf("t3_last_c%0d", i), 32'(m_last), 32'(acc % 4 == 3));
        if (m_valid && m_ready) begin
          chk($sformatf("t3_data_c%0d", i), 32'(m_data), 32'(sbq.pop_front()));
          exp_done = (acc % 4 == 3);
          acc++;
        end else begin
          exp_done = 1'b0;
        end
      end
      chk("t3_accepted", 32'(acc), 32'd8);
    end

    // Test 4: en low with a full skid buffer; drains 2, resumes at beat 2
    apply(v(1,0,0, 0,0,8'h00,0,0,1), "t4_idle");
    push0(8'hB1); push0(8'hB2); push0(8'hB3); push0(8'hB4); push0(8'hB5);
    apply(v(1,0,0, 1,0,8'h00,0,0,0), "t4_c0");
    apply(v(1,0,0, 1,1,8'hB1,0,0,0), "t4_c1");
    apply(v(0,1,0, 0,1,8'hB1,0,0,0), "t4_c2");
    apply(v(0,1,0, 0,1,8'hB2,0,1,0), "t4_c3");
    apply(v(0,1,0, 0,0,8'h00,0,2,0), "t4_c4");
    apply(v(1,0,0, 1,0,8'h00,0,2,0), "t4_c5");
    apply(v(1,1,0, 1,1,8'hB3,0,2,0), "t4_c6");
    apply(v(1,1,0, 1,1,8'hB4,1,3,0), "t4_c7");
    apply(v(1,1,0, 0,1,8'hB5,0,0,1), "t4_c8");

    // Test 5: asynchronous reset mid-burst at beat 2 with occ=2
    push0(8'hC1); push0(8'hC2); push0(8'hC3); push0(8'hC4);
    apply(v(1,1,0, 1,0,8'h00,0,1,0), "t5_c0");
    apply(v(1,1,0, 1,1,8'hC1,0,1,0), "t5_c1");
    apply(v(1,0,0, 1,1,8'hC2,0,2,0), "t5_c2");
    apply(v(1,0,0, 0,1,8'hC2,0,2,0), "t5_c3");
    #2;
    rst = 1'b0;
    #1;
    chk("t5_arst_rinc",  32'(rinc),       32'd0);
    chk("t5_arst_valid", 32'(m_valid),    32'd0);
    chk("t5_arst_data",  32'(m_data),     32'd0);
    chk("t5_arst_last",  32'(m_last),     32'd0);
    chk("t5_arst_beat",  32'(beat_cnt),   32'd0);
    chk("t5_arst_done",  32'(burst_done), 32'd0);
    @(negedge clk);
    force_empty = 1'b1;
    rst = 1'b1;
    apply(v(1,0,0, 1,0,8'h00,0,0,0), "t5_c4");
    apply(v(1,1,0, 0,1,8'hC4,0,0,0), "t5_c5");

    // Test 6: BURST_LEN=1 instance, every beat is last
    begin
      logic       e_rinc [6] = '{1, 1, 1, 0, 0, 0};
      logic       e_valid[6] = '{0, 1, 1, 1, 0, 0};
      logic [7:0] e_data [6] = '{8'h00, 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'h00};
      logic       e_done [6] = '{0, 0, 1, 1, 1, 0};
      push1(8'hD1); push1(8'hD2); push1(8'hD3);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        en = 1'b1; m_ready = 1'b0; m_ready1 = 1'b1; force_empty = 1'b0;
        #1;
        chk($sformatf("t6_rinc_c%0d", i),  32'(rinc1),       32'(e_rinc[i]));
        chk($sformatf("t6_valid_c%0d", i), 32'(m_valid1),    32'(e_valid[i]));
        if (e_valid[i]) chk($sformatf("t6_data_c%0d", i), 32'(m_data1), 32'(e_data[i]));
        chk($sformatf("t6_last_c%0d", i),  32'(m_last1),     32'(e_valid[i]));
        chk($sformatf("t6_beat_c%0d", i),  32'(beat_cnt1),   32'd0);
        chk($sformatf("t6_done_c%0d", i),  32'(burst_done1), 32'(e_done[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer stage for the asynchronous FIFO. It runs entirely in the read clock domain and pops words through the FIFO's first-word-fall-through read port (rinc/rdata/rempty). It re-presents those words as a registered valid/ready stream with a 2-entry skid buffer and frames the stream into fixed-length bursts using m_last. rinc has no combinational path from m_ready.

Parameters:
DSIZE, 8, data width; matches the FIFO DSIZE.
BURST_LEN, 4, beats per burst; legal range 1..2^CW.
CW, 4, width of the beat counter.

Ports:
clk  input  1  read-domain clock; the same clock as the FIFO rclk.
rst  input  1  asynchronous, active-low reset.
en  input  1  pop enable; when low, no new pops occur and buffered words still drain.
rempty  input  1  FIFO empty flag, synchronous to clk.
rdata  input  DSIZE  FIFO head word; valid whenever rempty=0.
rinc  output  1  FIFO pop strobe.
m_valid  output  1  output word valid.
m_ready  input  1  downstream accept.
m_data  output  DSIZE  output word.
m_last  output  1  final beat of the current burst.
beat_cnt  output  CW  index of the current beat within the burst.
burst_done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-low.
- Storage: head register, skid register, and occupancy occ in 0..2.
- rinc = rst & en & ~rempty & (occ != 2).
  - rinc is combinational only from registered state and rempty.
  - rinc is forced low while rst=0.
- Output mapping:
  - m_valid = (occ != 0), decoded from a register.
  - m_data = head.
  - m_last = m_valid & (beat_cnt == BURST_LEN-1).
- Handshake: hs = m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_last and m_valid hold stable.
- Transitions per clk edge (pop = rinc):
  - occ=0, pop: head<=rdata; occ->1.
  - occ=1, pop, no hs: skid<=rdata; occ->2.
  - occ=1, pop, hs: head<=rdata; occ stays 1.
  - occ=1, no pop, hs: occ->0.
  - occ=2, hs: head<=skid; occ->1. No pop is possible at occ=2.
  - No pop and no hs: everything holds.
- Latency: rempty falls before edge N. The word pops at edge N, and m_valid=1 after edge N (1 cycle).
- Throughput: 1 word per cycle while the FIFO is non-empty and m_ready=1.
- Beat counter, on hs:
  - If beat_cnt == BURST_LEN-1: beat_cnt<=0 and burst_done<=1 for one cycle.
  - Otherwise: beat_cnt<=beat_cnt+1.
  - burst_done is 0 in every other cycle.
  - BURST_LEN=1: m_last=1 on every valid beat.
- en low: rinc=0. Buffered words still drain. beat_cnt holds position across en toggles; en does not restart a burst.
- rempty toggling mid-burst: the stream pauses (m_valid may drop) and beat_cnt holds. m_last is asserted only on the true final beat.
- Reset (including reset mid-burst):
  - occ=0, m_valid=0, m_data=0, m_last=0, beat_cnt=0, burst_done=0, rinc=0.
  - Buffered words are discarded.
- Ordering: output order equals FIFO pop order. No duplication, no loss.

Test Plan:
1. Reset, FIFO holding 0x11,0x22,0x33,0x44, m_ready=1, en=1 -> rinc high 4 consecutive cycles; m_data 0x11..0x44 on 4 consecutive cycles starting 1 cycle after first pop; m_last only with 0x44; burst_done pulses the cycle after; beat_cnt returns to 0.
2. FIFO full stream, m_ready=0 for 5 cycles then 1 -> exactly 2 pops (occ=2), then rinc=0; m_data holds first word stable; after release, words emerge in order with no gap and no loss.
3. m_ready toggling 1,0,1,0 with rempty alternating each cycle -> output sequence equals input sequence; beat_cnt advances only on hs; m_last on every 4th accepted beat.
4. en=0 with occ=2 and m_ready=1 -> 2 words drain, rinc stays 0, m_valid falls; en=1 resumes at beat_cnt=2.
5. rst asserted asynchronously mid-burst (beat_cnt=2, occ=2) -> all outputs 0 immediately, without a clock; after release, the next word starts at beat_cnt=0.
6. BURST_LEN=1, 3 words -> m_last=1 and burst_done pulse for each of the 3 beats.
